cve2_register_file_mp: RTL and testbench
========================================

# cve2_register_file_mp

Parametrised flip-flop register file for the CVE2 core: configurable number of read ports, two write ports, optional same-cycle write-to-read bypass and a per-register pending scoreboard for late (LSU / multi-cycle) writeback. It replaces the single-write-port FF register file in the decode/writeback path when the core retires loads or multiplier results out of band. It targets FPGA synthesis and Verilator simulation.

## Interface
- `RV32E`, 0: 1 selects 16 registers (ADDR_WIDTH 4); 0 selects 32 registers (ADDR_WIDTH 5).
- `DataWidth`, 32: word width.
- `WordZeroVal`, '0: value of x0 and the reset value of every register.
- `NumReadPorts`, 2: number of read ports, legal range 1..4.
- `WriteBypass`, 1: 1 lets a same-cycle write appear on the read data; 0 means a read returns only the stored value.

Ports:
- `clk_i`  in  1  clock. All state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `test_en_i`  in  1  unused. Kept for drop-in compatibility.
- `raddr_i`  in  NumReadPorts x 5  read addresses.
- `rdata_o`  out  NumReadPorts x DataWidth  read data.
- `rbusy_o`  out  NumReadPorts  the addressed register has an outstanding reservation.
- `waddr_a_i`, `wdata_a_i`, `we_a_i`  in  5 / DataWidth / 1  write port A (in-order ALU writeback).
- `waddr_b_i`, `wdata_b_i`, `we_b_i`  in  5 / DataWidth / 1  write port B (late writeback). A port B write clears the reservation on its address.
- `rsv_addr_i`, `rsv_i`  in  5 / 1  reserve a register for a pending late write.
- `pending_any_o`  out  1  at least one reservation is outstanding.

## Operation
- **x0**
  - Always reads WordZeroVal.
  - Writes and reservations to x0 are ignored.
  - x0 is never busy.
- **RV32E mode**
  - Any address with bit 4 set is illegal.
  - Illegal writes and reservations are ignored.
  - Illegal reads return WordZeroVal with rbusy 0.
- **Write collision**
  - When A and B both write the same address in one cycle, port A data is stored.
  - The reservation on that address is still cleared.
- **Reservation**
  - `rsv_i` sets `pending_q[rsv_addr_i]`.
  - A port B write clears `pending_q[waddr_b_i]`.
  - A port A write has no effect on pending bits.
  - If the reserve and the clear hit the same address in one cycle, the reserve wins and the bit stays 1 (new outstanding writer).
  - Reserving an address that is already pending keeps it at 1. There is no counting.
- **Read data, WriteBypass=1**
  - If `we_a_i` is set and `waddr_a_i` equals the read address, return `wdata_a_i`.
  - Otherwise, if `we_b_i` is set and `waddr_b_i` equals the read address, return `wdata_b_i`.
  - Otherwise, return the stored value.
- **Read data, WriteBypass=0**: always the stored value.
- **rbusy, WriteBypass=1**: `pending_q[addr]` AND NOT (`we_b_i` AND `waddr_b_i` == addr).
- **rbusy, WriteBypass=0**: `pending_q[addr]`.
- **pending_any_o**: OR of `pending_q`, registered state only. It does not look ahead to same-cycle clears.

## Timing
- Reset (asynchronous assert) puts every register to WordZeroVal and every pending bit to 0.
- During reset, `rdata_o` = WordZeroVal, `rbusy_o` = 0 and `pending_any_o` = 0.
- Reads are combinational, zero cycles.
- Writes and reservations are visible in stored state one cycle after the edge that samples them.
- With bypass enabled, reads see a write in the same cycle it is presented.
- Reset asserted mid-operation drops all reservations. A late write arriving after reset deassertion is a normal write; it clears an already-clear bit.
- There is no stall or back-pressure. Every request is accepted every cycle.

## Structure
- Package `cve2_rf_pkg` holds:
  - `localparam` helpers for ADDR_WIDTH / NUM_WORDS derived from RV32E;
  - the `rf_addr_t` typedef (logic [4:0]);
  - the maximum read-port count, 4.
- Sub-module `cve2_rf_scoreboard` holds the pending-bit array, reserve/clear priority and `pending_any_o`. It exports `pending_q` to the parent.
- Data flops, write decode, collision priority and read/bypass muxing stay in the top module, as one generate loop over read ports.

## Test plan
- **Reset and write**: reset, then read x1..x31 → all 0, rbusy 0. Write A x5=0xDEADBEEF; next cycle read x5 → 0xDEADBEEF, and read x0 → 0.
- **Collision and bypass**: WriteBypass=1, same cycle A writes x7=0x11 and B writes x7=0x22, port 0 reads x7 → rdata 0x11 combinationally. Next cycle x7 reads 0x11.
- **Reservation lifecycle**: reserve x9 → next cycle rbusy=1 and pending_any_o=1. B writes x9=0x55 → rbusy 0 in the same cycle (bypass), rdata 0x55. Next cycle pending_any_o=0.
- **Reserve/clear same cycle**: x3 pending; in one cycle reserve x3 and B writes x3=0x99 → next cycle x3 reads 0x99 and rbusy remains 1.
- **RV32E**: RV32E=1, write A x20=0x1234 then read x20 → 0. Then write x4=0xAB and read x20 → 0, x4 → 0xAB.
- **Reset mid-operation and no bypass**: reserve x12, assert rst_ni mid-cycle → pending_any_o=0 asynchronously. With WriteBypass=0, a same-cycle write x2=0x7 reads the old value 0, then 0x7 the next cycle.

Source files
------------

// File: rtl/cve2_rf_pkg.sv
// Shared types and sizing helpers for the CVE2 multi-port register file.
package cve2_rf_pkg;

   localparam int unsigned RF_MAX_READ_PORTS = 4;
   localparam int unsigned RF_ADDR_WIDTH_I   = 5;
   localparam int unsigned RF_ADDR_WIDTH_E   = 4;

   typedef logic [4:0] rf_addr_t;

   function automatic int unsigned rf_addr_width(bit rv32e);
      return rv32e ? RF_ADDR_WIDTH_E : RF_ADDR_WIDTH_I;
   endfunction

   function automatic int unsigned rf_num_words(bit rv32e);
      return 32'd1 << rf_addr_width(rv32e);
   endfunction

   // x0 and, in RV32E, addresses 16..31 are never stored, reserved or reported busy.
   function automatic logic rf_addr_legal(rf_addr_t addr, bit rv32e);
      return (addr != '0) && !(rv32e && addr[4]);
   endfunction

endpackage

// File: rtl/cve2_rf_scoreboard.sv
// Per-register pending bits for late writeback: reserve sets, port B write clears.
module cve2_rf_scoreboard
   import cve2_rf_pkg::*;
#(
   parameter bit          RV32E    = 1'b0,
   parameter int unsigned NumWords = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rsv_i,
   input  logic [4:0]          rsv_addr_i,
   input  logic                we_b_i,
   input  logic [4:0]          waddr_b_i,
   output logic [NumWords-1:0] pending_o,
   output logic                pending_any_o
);

   localparam int unsigned AddrWidth = $clog2(NumWords);

   logic [NumWords-1:0] pending_d;
   logic [NumWords-1:0] pending_q;

   always_comb begin
      pending_d = pending_q;
      if (we_b_i && rf_addr_legal(waddr_b_i, RV32E)) begin
         pending_d[waddr_b_i[AddrWidth-1:0]] = 1'b0;
      end
      // Reserve applied last: a new writer in the same cycle keeps the bit set.
      if (rsv_i && rf_addr_legal(rsv_addr_i, RV32E)) begin
         pending_d[rsv_addr_i[AddrWidth-1:0]] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending_o     = pending_q;
   assign pending_any_o = |pending_q;

endmodule

// File: rtl/cve2_register_file_mp.sv
// Flip-flop register file with N read ports, two write ports, optional bypass
// and a pending scoreboard for out-of-band writeback.
module cve2_register_file_mp
   import cve2_rf_pkg::*;
#(
   parameter bit                   RV32E        = 1'b0,
   parameter int unsigned          DataWidth    = 32,
   parameter logic [DataWidth-1:0] WordZeroVal  = '0,
   parameter int unsigned          NumReadPorts = 2,
   parameter bit                   WriteBypass  = 1'b1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              test_en_i,
   input  logic [NumReadPorts*5-1:0]         raddr_i,
   output logic [NumReadPorts*DataWidth-1:0] rdata_o,
   output logic [NumReadPorts-1:0]           rbusy_o,
   input  logic [4:0]                        waddr_a_i,
   input  logic [DataWidth-1:0]              wdata_a_i,
   input  logic                              we_a_i,
   input  logic [4:0]                        waddr_b_i,
   input  logic [DataWidth-1:0]              wdata_b_i,
   input  logic                              we_b_i,
   input  logic [4:0]                        rsv_addr_i,
   input  logic                              rsv_i,
   output logic                              pending_any_o
);

   localparam int unsigned NumWords  = rf_num_words(RV32E);
   localparam int unsigned AddrWidth = rf_addr_width(RV32E);

   logic [NumWords-1:0][DataWidth-1:0] mem_d;
   logic [NumWords-1:0][DataWidth-1:0] mem_q;
   logic [NumWords-1:0]                pending;
   logic                               unused_test_en;

   assign unused_test_en = test_en_i;

   always_comb begin
      mem_d = mem_q;
      if (we_b_i && rf_addr_legal(waddr_b_i, RV32E)) begin
         mem_d[waddr_b_i[AddrWidth-1:0]] = wdata_b_i;
      end
      // Port A written last so it wins a same-address collision.
      if (we_a_i && rf_addr_legal(waddr_a_i, RV32E)) begin
         mem_d[waddr_a_i[AddrWidth-1:0]] = wdata_a_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= {NumWords{WordZeroVal}};
      end else begin
         mem_q <= mem_d;
      end
   end

   cve2_rf_scoreboard #(
      .RV32E    (RV32E),
      .NumWords (NumWords)
   ) u_scoreboard (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .rsv_i         (rsv_i),
      .rsv_addr_i    (rsv_addr_i),
      .we_b_i        (we_b_i),
      .waddr_b_i     (waddr_b_i),
      .pending_o     (pending),
      .pending_any_o (pending_any_o)
   );

   for (genvar g = 0; g < NumReadPorts; g++) begin : gen_rd
      rf_addr_t             ra;
      logic [DataWidth-1:0] rd_data;
      logic                 rd_busy;

      assign ra = raddr_i[g*5 +: 5];

      always_comb begin
         rd_data = mem_q[ra[AddrWidth-1:0]];
         rd_busy = pending[ra[AddrWidth-1:0]];
         if (WriteBypass) begin
            if (we_b_i && (waddr_b_i == ra)) begin
               rd_data = wdata_b_i;
               rd_busy = 1'b0;
            end
            if (we_a_i && (waddr_a_i == ra)) begin
               rd_data = wdata_a_i;
            end
         end
         // Gating on reset keeps a bypassed write from leaking out while held in reset.
         if (!rst_ni || !rf_addr_legal(ra, RV32E)) begin
            rd_data = WordZeroVal;
            rd_busy = 1'b0;
         end
      end

      assign rdata_o[g*DataWidth +: DataWidth] = rd_data;
      assign rbusy_o[g]                        = rd_busy;
   end

endmodule

// File: tb/tb_cve2_register_file_mp.sv
// Self-checking bench: three configurations driven in parallel against an array model.
module tb_cve2_register_file_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [14:0] raddr = '0;
   logic [4:0]  waddr_a = '0, waddr_b = '0, rsv_addr = '0;
   logic [31:0] wdata_a = '0, wdata_b = '0;
   logic        we_a = 1'b0, we_b = 1'b0, rsv = 1'b0;
   logic        run = 1'b0;

   logic [95:0] rdata_a;
   logic [63:0] rdata_e, rdata_n;
   logic [2:0]  rbusy_a;
   logic [1:0]  rbusy_e, rbusy_n;
   logic        any_a, any_e, any_n;

   int checks = 0;
   int fails  = 0;

   // Reference state: full 32-entry view for RV32I, separate state for RV32E.
   logic [31:0] mem  [32];
   logic [31:0] memE [32];
   logic [31:0] pend, pendE;

   always #5 clk = ~clk;

   cve2_register_file_mp #(
      .RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0), .NumReadPorts(3), .WriteBypass(1'b1)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .raddr_i(raddr), .rdata_o(rdata_a),
      .rbusy_o(rbusy_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
      .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv_addr_i(rsv_addr),
      .rsv_i(rsv), .pending_any_o(any_a)
   );

   cve2_register_file_mp #(
      .RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0), .NumReadPorts(2), .WriteBypass(1'b1)
   ) dut_e (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .raddr_i(raddr[9:0]), .rdata_o(rdata_e),
      .rbusy_o(rbusy_e), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
      .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv_addr_i(rsv_addr),
      .rsv_i(rsv), .pending_any_o(any_e)
   );

   cve2_register_file_mp #(
      .RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0), .NumReadPorts(2), .WriteBypass(1'b0)
   ) dut_n (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b1), .raddr_i(raddr[9:0]), .rdata_o(rdata_n),
      .rbusy_o(rbusy_n), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
      .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv_addr_i(rsv_addr),
      .rsv_i(rsv), .pending_any_o(any_n)
   );

   function automatic bit legal(int a, bit e);
      return (a != 0) && !(e && a >= 16);
   endfunction

   function automatic logic [31:0] exp_rd(int a, bit e, bit byp);
      if (!rst_n || !legal(a, e)) return 32'h0;
      if (byp && we_a && int'(waddr_a) == a) return wdata_a;
      if (byp && we_b && int'(waddr_b) == a) return wdata_b;
      return e ? memE[a] : mem[a];
   endfunction

   function automatic logic [31:0] exp_busy(int a, bit e, bit byp);
      logic p;
      if (!rst_n || !legal(a, e)) return 32'h0;
      p = e ? pendE[a] : pend[a];
      if (byp && we_b && int'(waddr_b) == a) return 32'h0;
      return {31'h0, p};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state update: B then A for data (A wins), clear then reserve for pending.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            mem[i]  <= 32'h0;
            memE[i] <= 32'h0;
         end
         pend  <= '0;
         pendE <= '0;
      end else begin
         if (we_b && legal(int'(waddr_b), 1'b0)) begin
            mem[waddr_b]  <= wdata_b;
            pend[waddr_b] <= 1'b0;
         end
         if (we_b && legal(int'(waddr_b), 1'b1)) begin
            memE[waddr_b]  <= wdata_b;
            pendE[waddr_b] <= 1'b0;
         end
         if (we_a && legal(int'(waddr_a), 1'b0)) mem[waddr_a]  <= wdata_a;
         if (we_a && legal(int'(waddr_a), 1'b1)) memE[waddr_a] <= wdata_a;
         if (rsv && legal(int'(rsv_addr), 1'b0)) pend[rsv_addr]  <= 1'b1;
         if (rsv && legal(int'(rsv_addr), 1'b1)) pendE[rsv_addr] <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (run) begin
         for (int p = 0; p < 3; p++) begin
            chk("rdata_a", rdata_a[p*32 +: 32], exp_rd(int'(raddr[p*5 +: 5]), 1'b0, 1'b1));
            chk("rbusy_a", {31'h0, rbusy_a[p]}, exp_busy(int'(raddr[p*5 +: 5]), 1'b0, 1'b1));
         end
         for (int p = 0; p < 2; p++) begin
            chk("rdata_e", rdata_e[p*32 +: 32], exp_rd(int'(raddr[p*5 +: 5]), 1'b1, 1'b1));
            chk("rbusy_e", {31'h0, rbusy_e[p]}, exp_busy(int'(raddr[p*5 +: 5]), 1'b1, 1'b1));
            chk("rdata_n", rdata_n[p*32 +: 32], exp_rd(int'(raddr[p*5 +: 5]), 1'b0, 1'b0));
            chk("rbusy_n", {31'h0, rbusy_n[p]}, exp_busy(int'(raddr[p*5 +: 5]), 1'b0, 1'b0));
         end
         chk("pending_any_a", {31'h0, any_a}, {31'h0, |pend});
         chk("pending_any_e", {31'h0, any_e}, {31'h0, |pendE});
         chk("pending_any_n", {31'h0, any_n}, {31'h0, |pend});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we_a = 1'b0;
      we_b = 1'b0;
      rsv  = 1'b0;
   endtask

   function automatic logic [4:0] rnd_addr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
   endfunction

   initial begin
      #1 rst_n = 1'b0;
      run = 1'b1;
      @(negedge clk);
      chk("reset_any", {31'h0, any_a}, 32'h0);
      tick();
      rst_n = 1'b1;

      // Reset state of every register.
      for (int i = 1; i < 32; i++) begin
         tick();
         raddr[4:0] = 5'(i);
         @(negedge clk);
         chk("reset_rd", rdata_a[31:0], 32'h0);
         chk("reset_busy", {31'h0, rbusy_a[0]}, 32'h0);
      end

      tick();
      we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF;
      tick();
      idle();
      raddr[4:0] = 5'd5; raddr[9:5] = 5'd0;
      @(negedge clk);
      chk("write_x5", rdata_a[31:0], 32'hDEADBEEF);
      chk("read_x0", rdata_a[63:32], 32'h0);

      // Collision: A wins, bypass shows it immediately.
      tick();
      we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
      we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
      raddr[4:0] = 5'd7;
      @(negedge clk);
      chk("collide_bypass", rdata_a[31:0], 32'h11);
      tick();
      idle();
      @(negedge clk);
      chk("collide_stored", rdata_a[31:0], 32'h11);
      chk("collide_stored_n", rdata_n[31:0], 32'h11);

      // Reservation lifecycle on x9.
      tick();
      rsv = 1'b1; rsv_addr = 5'd9;
      tick();
      idle();
      raddr[4:0] = 5'd9;
      @(negedge clk);
      chk("rsv_busy", {31'h0, rbusy_a[0]}, 32'h1);
      chk("rsv_any", {31'h0, any_a}, 32'h1);
      tick();
      we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h55;
      @(negedge clk);
      chk("late_busy", {31'h0, rbusy_a[0]}, 32'h0);
      chk("late_rd", rdata_a[31:0], 32'h55);
      chk("late_any_reg", {31'h0, any_a}, 32'h1);
      tick();
      idle();
      @(negedge clk);
      chk("late_any_clr", {31'h0, any_a}, 32'h0);

      // Reserve and clear on the same address in one cycle.
      tick();
      rsv = 1'b1; rsv_addr = 5'd3;
      tick();
      we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h99;
      tick();
      idle();
      raddr[4:0] = 5'd3;
      @(negedge clk);
      chk("rsvclr_rd", rdata_a[31:0], 32'h99);
      chk("rsvclr_busy", {31'h0, rbusy_a[0]}, 32'h1);
      tick();
      we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h99;
      tick();
      idle();

      // RV32E illegal address.
      we_a = 1'b1; waddr_a = 5'd20; wdata_a = 32'h1234;
      tick();
      idle();
      raddr[4:0] = 5'd20;
      @(negedge clk);
      chk("e_x20", rdata_e[31:0], 32'h0);
      chk("i_x20", rdata_a[31:0], 32'h1234);
      tick();
      we_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'hAB;
      tick();
      idle();
      raddr[9:5] = 5'd4;
      @(negedge clk);
      chk("e_x20_again", rdata_e[31:0], 32'h0);
      chk("e_x4", rdata_e[63:32], 32'hAB);

      // Asynchronous reset drops reservations mid-cycle.
      tick();
      rsv = 1'b1; rsv_addr = 5'd12;
      tick();
      idle();
      @(negedge clk);
      chk("pre_rst_any", {31'h0, any_a}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_any_a", {31'h0, any_a}, 32'h0);
      chk("async_rst_any_n", {31'h0, any_n}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // No-bypass read returns the stored value until the write lands.
      tick();
      we_a = 1'b1; waddr_a = 5'd2; wdata_a = 32'h7;
      raddr[4:0] = 5'd2;
      @(negedge clk);
      chk("nobyp_old", rdata_n[31:0], 32'h0);
      chk("byp_new", rdata_a[31:0], 32'h7);
      tick();
      idle();
      @(negedge clk);
      chk("nobyp_new", rdata_n[31:0], 32'h7);

      // Randomized traffic, including late writes after reset and rare reset pulses.
      for (int c = 0; c < 3000; c++) begin
         tick();
         we_a     = ($urandom_range(0, 1) == 0);
         we_b     = ($urandom_range(0, 4) < 2);
         rsv      = ($urandom_range(0, 9) < 3);
         waddr_a  = rnd_addr();
         waddr_b  = ($urandom_range(0, 3) == 0) ? waddr_a : rnd_addr();
         rsv_addr = ($urandom_range(0, 3) == 0) ? waddr_b : rnd_addr();
         wdata_a  = $urandom;
         wdata_b  = $urandom;
         for (int p = 0; p < 3; p++) begin
            case ($urandom_range(0, 4))
               0: raddr[p*5 +: 5] = waddr_a;
               1: raddr[p*5 +: 5] = waddr_b;
               2: raddr[p*5 +: 5] = rsv_addr;
               default: raddr[p*5 +: 5] = rnd_addr();
            endcase
         end
         if ($urandom_range(0, 299) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      tick();
      idle();
      @(negedge clk);
      run = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
